// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM pattern tester: FSM state encoding,
// LFSR tap mask (x^16+x^14+x^13+x^11+1), default seed and the LFSR step function.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    RD_REQ = 3'd2,
    PASS   = 3'd3,
    FAIL   = 3'd4
  } state_e;

  // Right-shifting Fibonacci form: feedback = xor of bits 0, 2, 3, 5, inserted at bit 15.
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/sdram_lfsr.sv
// 16-bit pattern LFSR: load has priority over advance; holds otherwise.
module sdram_lfsr
  import sdram_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (advance) begin
      value_d = lfsr_next(value_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= LFSR_DEFAULT_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM write/read-back pattern tester driving a controller host port.
// Optional SDRAM_TEST_ERRCNT_EN: adds err_cnt_o and keeps sweeping after mismatches.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = {ADDR_W{1'b1}},
  parameter logic [15:0]       LFSR_SEED  = LFSR_DEFAULT_SEED,
  parameter int                TIMEOUT    = 1024
) (
  input  logic              master_clk_i,
  input  logic              rst_i,
  output logic              wr_o,
  output logic              rd_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              done_i,
  output logic              pass_o,
  output logic              fail_o,
  output logic              led_o
`ifdef SDRAM_TEST_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt_o
`endif
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              gap_q, gap_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              lfsr_load, lfsr_adv;
  logic [15:0]       lfsr_value;
  logic              req_active, op_done, op_timeout, last_addr, rd_mismatch;
`ifdef SDRAM_TEST_ERRCNT_EN
  logic [15:0]       err_q, err_d;
`endif

  sdram_lfsr u_lfsr (
    .clk    (master_clk_i),
    .rst    (rst_i),
    .load   (lfsr_load),
    .seed   (LFSR_SEED),
    .advance(lfsr_adv),
    .value  (lfsr_value)
  );

  // gap_q idles the request for one cycle after each done so the controller
  // sees a clean deassertion between back-to-back operations.
  assign req_active  = ((state_q == WR_REQ) || (state_q == RD_REQ)) && !gap_q;
  assign op_done     = req_active && done_i;
  assign op_timeout  = req_active && !done_i && (tmo_q == TMO_LAST);
  assign last_addr   = (addr_q == END_ADDR);
  assign rd_mismatch = (data_i != DATA_W'(lfsr_value));

  // NOTE: every variable gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    gap_d     = 1'b0;
    tmo_d     = '0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
`ifdef SDRAM_TEST_ERRCNT_EN
    err_d     = err_q;
`endif
    if (req_active && !done_i) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        addr_d    = START_ADDR;
        lfsr_load = 1'b1;
        state_d   = WR_REQ;
      end
      WR_REQ: begin
        if (op_timeout) begin
          state_d = FAIL;
        end else if (op_done) begin
          gap_d    = 1'b1;
          lfsr_adv = 1'b1;
          if (last_addr) begin
            addr_d    = START_ADDR;
            lfsr_load = 1'b1;
            state_d   = RD_REQ;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      RD_REQ: begin
        if (op_timeout) begin
          state_d = FAIL;
        end else if (op_done) begin
          gap_d = 1'b1;
`ifdef SDRAM_TEST_ERRCNT_EN
          if (rd_mismatch && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end
          if (last_addr) begin
            state_d = ((err_q == 16'd0) && !rd_mismatch) ? PASS : FAIL;
          end else begin
            addr_d   = addr_q + ADDR_W'(1);
            lfsr_adv = 1'b1;
          end
`else
          if (rd_mismatch) begin
            state_d = FAIL;
          end else if (last_addr) begin
            state_d = PASS;
          end else begin
            addr_d   = addr_q + ADDR_W'(1);
            lfsr_adv = 1'b1;
          end
`endif
        end
      end
      PASS:    state_d = PASS;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge master_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= START_ADDR;
      gap_q   <= 1'b0;
      tmo_q   <= '0;
`ifdef SDRAM_TEST_ERRCNT_EN
      err_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
`ifdef SDRAM_TEST_ERRCNT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  assign wr_o   = (state_q == WR_REQ) && !gap_q;
  assign rd_o   = (state_q == RD_REQ) && !gap_q;
  assign addr_o = addr_q;
  assign data_o = (state_q == WR_REQ) ? DATA_W'(lfsr_value) : '0;
  assign pass_o = (state_q == PASS);
  assign fail_o = (state_q == FAIL);
  assign led_o  = pass_o;
`ifdef SDRAM_TEST_ERRCNT_EN
  assign err_cnt_o = err_q;
`endif

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester: 4-word sweep against a 3-cycle memory model.
module tb_sdram_pattern_tester;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              wr_o, rd_o, pass_o, fail_o, led_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] data_i = '0;
  logic              model_done = 1'b0;
  logic              stray_done = 1'b0;
  logic              done_i;
`ifdef SDRAM_TEST_ERRCNT_EN
  logic [15:0]       err_cnt_o;
`endif

  assign done_i = model_done | stray_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_pattern_tester #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .START_ADDR(24'd0),
    .END_ADDR  (24'd3),
    .TIMEOUT   (8)
  ) dut (
    .master_clk_i(clk),
    .rst_i       (rst_i),
    .wr_o        (wr_o),
    .rd_o        (rd_o),
    .addr_o      (addr_o),
    .data_o      (data_o),
    .data_i      (data_i),
    .done_i      (done_i),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .led_o       (led_o)
`ifdef SDRAM_TEST_ERRCNT_EN
    ,
    .err_cnt_o   (err_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model configuration, written only by the stimulus process.
  logic [15:0] flip [8];
  bit          mute;

  // Model state and logs, written only by the model process (cleared during reset).
  logic [15:0]       mem [4];
  int                age, wr_cnt, rd_issued, rd_done, both_err, gap_err, hold_err;
  bit                op_is_rd;
  logic [ADDR_W-1:0] hold_addr;
  logic [15:0]       hold_data;
  logic [ADDR_W-1:0] wr_addr_log [8];
  logic [15:0]       wr_data_log [8];
  logic              fail_after_rd [8];

  always @(negedge clk or posedge rst_i) begin
    if (rst_i) begin
      age = 0; model_done = 1'b0; wr_cnt = 0; rd_issued = 0; rd_done = 0;
      both_err = 0; gap_err = 0; hold_err = 0; op_is_rd = 1'b0;
      for (int i = 0; i < 8; i++) fail_after_rd[i] = 1'b0;
    end else begin
      if (wr_o && rd_o) both_err++;
      if (model_done) begin
        model_done = 1'b0;
        age = 0;
        if (wr_o || rd_o) gap_err++;
        if (op_is_rd) begin
          if (rd_done < 8) fail_after_rd[rd_done] = fail_o;
          rd_done++;
        end
      end else if ((wr_o || rd_o) && !mute) begin
        age++;
        if (age == 1) begin
          hold_addr = addr_o;
          hold_data = data_o;
          op_is_rd  = rd_o;
          if (rd_o) rd_issued++;
        end else if ((addr_o !== hold_addr) || (wr_o && (data_o !== hold_data))) begin
          hold_err++;
        end
        if (age == 3) begin
          model_done = 1'b1;
          if (wr_o) begin
            mem[addr_o[1:0]] = data_o;
            if (wr_cnt < 8) begin
              wr_addr_log[wr_cnt] = addr_o;
              wr_data_log[wr_cnt] = data_o;
            end
            wr_cnt++;
          end else if (rd_issued >= 1 && rd_issued <= 8) begin
            data_i = mem[addr_o[1:0]] ^ flip[rd_issued-1];
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_end(input string tag);
    int i = 0;
    while (!(pass_o || fail_o) && i < 300) begin
      tick(1);
      i++;
    end
    check(tag, 32'(pass_o || fail_o), 32'd1);
  endtask

  task automatic check_proto(input string tag);
    check({tag, "_both_high"}, 32'(both_err), 32'd0);
    check({tag, "_gap"},       32'(gap_err),  32'd0);
    check({tag, "_hold"},      32'(hold_err), 32'd0);
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_wr"},   32'(wr_o),   32'd0);
    check({tag, "_rd"},   32'(rd_o),   32'd0);
    check({tag, "_pass"}, 32'(pass_o), 32'd0);
    check({tag, "_fail"}, 32'(fail_o), 32'd0);
    check({tag, "_led"},  32'(led_o),  32'd0);
    check({tag, "_addr"}, 32'(addr_o), 32'd0);
    check({tag, "_data"}, 32'(data_o), 32'd0);
  endtask

  task automatic config_model(input bit mute_en);
    for (int i = 0; i < 8; i++) flip[i] = 16'h0000;
    mute = mute_en;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_pat [4];
    int n;
    exp_pat[0] = 16'hACE1; exp_pat[1] = 16'h5670;
    exp_pat[2] = 16'hAB38; exp_pat[3] = 16'h559C;

    // Reset values
    config_model(1'b0);
    tick(3);
    check_outputs_idle("reset");
`ifdef SDRAM_TEST_ERRCNT_EN
    check("reset_errcnt", 32'(err_cnt_o), 32'd0);
`endif

    // Release with a stray done_i during the IDLE cycle; first write must still be clean
    rst_i = 1'b0;
    stray_done = 1'b1;
    tick(1);
    stray_done = 1'b0;
    check("idle_stray_wr",   32'(wr_o),   32'd1);
    check("idle_stray_addr", 32'(addr_o), 32'd0);
    check("idle_stray_data", 32'(data_o), 32'hACE1);

    // Full pass sweep
    wait_end("pass_end");
    check("pass_pass", 32'(pass_o), 32'd1);
    check("pass_led",  32'(led_o),  32'd1);
    check("pass_fail", 32'(fail_o), 32'd0);
    check("pass_wr_cnt", 32'(wr_cnt), 32'd4);
    check("pass_rd_cnt", 32'(rd_done), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pass_wr_addr%0d", i), 32'(wr_addr_log[i]), 32'(i));
      check($sformatf("pass_wr_data%0d", i), 32'(wr_data_log[i]), 32'(exp_pat[i]));
    end
`ifdef SDRAM_TEST_ERRCNT_EN
    check("pass_errcnt", 32'(err_cnt_o), 32'd0);
`endif

    // Stray done_i while in PASS
    stray_done = 1'b1;
    tick(1);
    stray_done = 1'b0;
    tick(4);
    check("pass_stray_pass", 32'(pass_o), 32'd1);
    check("pass_stray_fail", 32'(fail_o), 32'd0);
    check("pass_stray_wr",   32'(wr_o),   32'd0);
    check("pass_stray_rd",   32'(rd_o),   32'd0);
    check("pass_stray_addr", 32'(addr_o), 32'd3);
    check("pass_stray_data", 32'(data_o), 32'd0);
    check_proto("pass");

    // Read-data corruption
    rst_i = 1'b1;
    tick(1);
    config_model(1'b0);
`ifdef SDRAM_TEST_ERRCNT_EN
    flip[1] = 16'h0001;
    flip[3] = 16'h0001;
`else
    flip[2] = 16'h0001;
`endif
    rst_i = 1'b0;
    wait_end("bad_end");
    check("bad_fail", 32'(fail_o), 32'd1);
    check("bad_pass", 32'(pass_o), 32'd0);
    check("bad_led",  32'(led_o),  32'd0);
`ifdef SDRAM_TEST_ERRCNT_EN
    check("bad_errcnt",     32'(err_cnt_o), 32'd2);
    check("bad_rd_done",    32'(rd_done), 32'd4);
    check("bad_fail_rd2",   32'(fail_after_rd[2]), 32'd0);
    check("bad_fail_rd3",   32'(fail_after_rd[3]), 32'd1);
`else
    check("bad_fail_rd1",   32'(fail_after_rd[1]), 32'd0);
    check("bad_fail_rd2",   32'(fail_after_rd[2]), 32'd1);
    check("bad_rd_issued",  32'(rd_issued), 32'd3);
    tick(20);
    check("bad_no_more_rd", 32'(rd_issued), 32'd3);
`endif
    check("bad_hold_rd", 32'(rd_o), 32'd0);
    check_proto("bad");

    // Timeout: the model never answers
    rst_i = 1'b1;
    tick(1);
    config_model(1'b1);
    rst_i = 1'b0;
    n = 0;
    while (!wr_o && n < 10) begin
      tick(1);
      n++;
    end
    check("tmo_wr_rise", 32'(wr_o), 32'd1);
    n = 0;
    while (!fail_o && n < 20) begin
      tick(1);
      n++;
    end
    check("tmo_fail",     32'(fail_o), 32'd1);
    check("tmo_latency",  32'(n >= 8 && n <= 9), 32'd1);
    check("tmo_wr_drop",  32'(wr_o), 32'd0);
    check("tmo_pass",     32'(pass_o), 32'd0);

    // Asynchronous reset during a read, then a complete rerun
    rst_i = 1'b1;
    tick(1);
    config_model(1'b0);
    rst_i = 1'b0;
    n = 0;
    while (!(rd_o && rd_issued >= 2) && n < 300) begin
      tick(1);
      n++;
    end
    check("rdmid_seen", 32'(rd_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check_outputs_idle("rdmid_async");
    tick(2);
    rst_i = 1'b0;
    wait_end("rerun_end");
    check("rerun_pass",      32'(pass_o), 32'd1);
    check("rerun_wr_cnt",    32'(wr_cnt), 32'd4);
    check("rerun_rd_cnt",    32'(rd_done), 32'd4);
    check("rerun_first_adr", 32'(wr_addr_log[0]), 32'd0);
    check("rerun_first_dat", 32'(wr_data_log[0]), 32'hACE1);
`ifdef SDRAM_TEST_ERRCNT_EN
    check("rerun_errcnt",    32'(err_cnt_o), 32'd0);
`endif
    check_proto("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_pattern_tester.md
SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 Parameter ADDR_W, default 24, host address width of the SDRAM controller.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter START_ADDR, default 0, first word address tested.
REQ-004 Parameter END_ADDR, default 2**ADDR_W-1, last word address tested (inclusive).
REQ-005 Parameter LFSR_SEED, default 16'hACE1, non-zero pattern seed.
REQ-006 Parameter TIMEOUT, default 1024, maximum cycles allowed per operation before failing.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-008 master_clk_i  in  1  sole clock; all state is updated on its rising edge.
REQ-009 rst_i  in  1  asynchronous active-high reset.
REQ-010 wr_o  out  1  write request to the SDRAM controller host port.
REQ-011 rd_o  out  1  read request to the SDRAM controller host port.
REQ-012 addr_o  out  ADDR_W  word address of the current request.
REQ-013 data_o  out  DATA_W  write data.
REQ-014 data_i  in  DATA_W  read data; valid only while done_i is high during a read.
REQ-015 done_i  in  1  one-cycle pulse from the controller marking completion of the current operation.
REQ-016 pass_o  out  1  test finished with no mismatch.
REQ-017 fail_o  out  1  mismatch or timeout detected.
REQ-018 led_o  out  1  equals pass_o.

Function
REQ-019 The FSM SHALL have the states IDLE, WR_REQ, RD_REQ, PASS and FAIL.
REQ-020 IDLE SHALL load the address to START_ADDR and the LFSR to LFSR_SEED, then enter WR_REQ on the next cycle.
REQ-021 In WR_REQ, wr_o SHALL be 1 and addr_o/data_o SHALL be held stable until the cycle done_i=1 is sampled.
REQ-022 On done_i in WR_REQ, the LFSR SHALL advance (x^16+x^14+x^13+x^11+1).
REQ-023 On done_i in WR_REQ, wr_o SHALL drop on the next cycle.
REQ-024 On done_i in WR_REQ, the address SHALL increment, or, if the address is END_ADDR, reload START_ADDR and LFSR_SEED and enter RD_REQ.
REQ-025 In RD_REQ, rd_o SHALL be 1 and addr_o SHALL be held stable until done_i=1.
REQ-026 In RD_REQ, on done_i the block SHALL compare data_i against the LFSR value.
REQ-027 A read mismatch SHALL enter FAIL.
REQ-028 A read match SHALL advance the LFSR and address, or enter PASS after END_ADDR.
REQ-029 wr_o and rd_o SHALL never be 1 in the same cycle.
REQ-030 A new request SHALL assert at the earliest one cycle after the previous done_i.
REQ-031 done_i sampled in IDLE, PASS or FAIL SHALL be ignored.
REQ-032 A per-operation cycle counter SHALL clear on every request start.
REQ-033 If the cycle counter reaches TIMEOUT without done_i, the block SHALL enter FAIL.
REQ-034 PASS and FAIL SHALL be terminal until reset.
REQ-035 pass_o=1 only in PASS and fail_o=1 only in FAIL.
REQ-036 If START_ADDR equals END_ADDR, the block SHALL run exactly one write and one read.

Reset
REQ-037 rst_i=1 SHALL immediately force IDLE and wr_o=rd_o=pass_o=fail_o=led_o=0, addr_o=START_ADDR and data_o=0, including mid-operation.
REQ-038 After rst_i deasserts, the test SHALL restart from IDLE.

Configuration
REQ-039 With SDRAM_TEST_ERRCNT_EN defined, a 16-bit output err_cnt_o SHALL be added.
REQ-040 With SDRAM_TEST_ERRCNT_EN defined, err_cnt_o SHALL reset to 0 and saturate at 16'hFFFF.
REQ-041 With SDRAM_TEST_ERRCNT_EN defined, a read mismatch SHALL increment err_cnt_o and the read sweep SHALL continue.
REQ-042 With SDRAM_TEST_ERRCNT_EN defined, the end of the sweep SHALL go to PASS if err_cnt_o is 0, else FAIL.
REQ-043 Without SDRAM_TEST_ERRCNT_EN, err_cnt_o SHALL be absent and the first mismatch SHALL enter FAIL.

Structure
REQ-044 The state encoding, the LFSR tap mask and the default seed SHALL reside in the shared package sdram_test_pkg.
REQ-045 The LFSR SHALL be the sub-module sdram_lfsr, with ports clk, rst, load, seed, advance and value.

Verification
REQ-046 Bench, START=0 and END=3, a memory model with done_i 3 cycles after each request: 4 writes with data 16'hACE1 and the next three LFSR values, then 4 reads, then pass_o=led_o=1.
REQ-047 Bench: flip bit 0 of read word 2 -> fail_o=1 on the cycle after that done_i, and no further rd_o.
REQ-048 Bench with SDRAM_TEST_ERRCNT_EN: corrupt reads 1 and 3 -> err_cnt_o=2 and fail_o=1 after the last read.
REQ-049 Bench, TIMEOUT=8: the model never returns done_i -> fail_o=1 within 9 cycles of wr_o rising.
REQ-050 Bench: rst_i pulsed while rd_o=1 -> outputs zero asynchronously, then a full rerun from address 0 ends with pass_o=1.
REQ-051 Bench: a stray done_i in IDLE and in PASS -> no state or output change, and wr_o/rd_o are never both high.
